// File: rtl/module_bin2bcd_display.sv
// Sequential double-dabble binary-to-BCD converter feeding the 8-digit scan display.
// One shift per clock; bcd_o only changes on completion so the display never shows partial results.
module module_bin2bcd_display #(
    parameter int BITS_BIN = 27,
    parameter int DIGITS   = 8
) (
    input  logic                  clk_10Mhz_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [BITS_BIN-1:0]   binary_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BITS_BIN);
    localparam logic [BITS_BIN-1:0] MAX_VAL = BITS_BIN'((10 ** DIGITS) - 1);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(BITS_BIN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BITS_BIN-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [BCD_W-1:0]    scratch_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;

    // Add-3 correction applied independently to every digit before the shift.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        bcd_d      = bcd_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_d   = binary_i;
                    scratch_d = '0;
                    cnt_d     = '0;
                    err_d     = (binary_i > MAX_VAL);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // An out-of-range value spends one evaluation cycle here without shifting.
                if (err_q) begin
                    state_d = DONE;
                end else begin
                    scratch_d = {scratch_adj[BCD_W-2:0], shift_q[BITS_BIN-1]};
                    shift_d   = {shift_q[BITS_BIN-2:0], 1'b0};
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                bcd_d      = err_q ? {DIGITS{4'hE}} : scratch_q;
                overflow_d = err_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_10Mhz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            bcd_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            bcd_q      <= bcd_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign bcd_o      = bcd_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign overflow_o = overflow_q;

endmodule
